// File: rtl/host_uart_command_dec_pkg.sv
// Shared definitions for the host UART command decoder and response encoder:
// command/response IDs, cmd_select encodings, frame geometry, error codes, FSM states.
package host_uart_cmd_pkg;

  localparam int HDR_BYTES         = 7;
  localparam int MAX_PAYLOAD_BYTES = 33;
  localparam int PAYLOAD_W         = 8 * MAX_PAYLOAD_BYTES;

  localparam logic [7:0] ENCRYPT_ENABLE_CMD_ID = 8'h01;
  localparam logic [7:0] ENCRYPT_ENABLE_RSP_ID = 8'h02;
  localparam logic [7:0] READ_YAW_CMD_ID       = 8'h03;
  localparam logic [7:0] READ_YAW_RSP_ID       = 8'h04;

  localparam logic [7:0] ENCRYPT_ENABLE_LEN = 8'd1;
  localparam logic [7:0] READ_YAW_LEN       = 8'd0;

  localparam logic [15:0] SEL_NONE           = 16'h0000;
  localparam logic [15:0] SEL_ENCRYPT_ENABLE = 16'h0001;
  localparam logic [15:0] SEL_READ_YAW       = 16'h0002;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_UNKNOWN_ID   = 2'd1,
    ERR_LEN_MISMATCH = 2'd2,
    ERR_TIMEOUT      = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CHECK,
    ST_OUT
  } dec_state_e;

endpackage

// File: rtl/host_uart_command_dec_if.sv
// Byte-stream input and decoded-command output of the host UART command decoder.
// slave = decoder side, master = UART receiver / command handler side.
interface host_uart_command_dec_if;
  import host_uart_cmd_pkg::*;

  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [15:0]          cmd_select;
  logic [PAYLOAD_W-1:0] cmd_payload;
  logic [5:0]           cmd_len;
  logic                 error;
  err_code_e            error_code;

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ready, cmd_valid, cmd_select, cmd_payload, cmd_len, error, error_code
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ready, cmd_valid, cmd_select, cmd_payload, cmd_len, error, error_code
  );

endinterface

// File: rtl/host_uart_command_dec.sv
// Host UART command decoder: frames 7-byte header + payload, validates ID/length.
// Optional inter-byte timeout enabled by defining HOST_UART_CMD_DEC_TIMEOUT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for byte0 (command ID)
// ST_HDR     | consuming header bytes 1..6, byte1 is payload length L
// ST_PAYLOAD | consuming L payload bytes, first 33 stored
// ST_CHECK   | one cycle: validate ID/L, load outputs or flag error
// ST_OUT     | cmd_valid held until cmd_ready
module host_uart_command_dec
  import host_uart_cmd_pkg::*;
`ifdef HOST_UART_CMD_DEC_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 100000
)
`endif
(
  input logic                     clk,
  input logic                     reset,
  host_uart_command_dec_if.slave  bus
);

  localparam logic [7:0] HDR_LAST    = 8'(HDR_BYTES - 1);
  localparam logic [7:0] MAX_PAY_8   = 8'(MAX_PAYLOAD_BYTES);
  localparam logic [5:0] MAX_PAY_6   = 6'(MAX_PAYLOAD_BYTES);

  dec_state_e           state_q, state_nxt;
  logic                 rx_ready_q;
  logic [7:0]           id_q, len_q, idx_q;
  logic [PAYLOAD_W-1:0] buf_q;
  logic [15:0]          cmd_select_q;
  logic [PAYLOAD_W-1:0] cmd_payload_q;
  logic [5:0]           cmd_len_q;
  logic                 error_q;
  err_code_e            error_code_q;

  logic                 accept;
  logic                 timeout_hit;
  logic                 load_cmd;
  logic                 err_set;
  err_code_e            err_nxt;
  logic [15:0]          sel_nxt;

  assign accept = bus.rx_valid && rx_ready_q;

`ifdef HOST_UART_CMD_DEC_TIMEOUT_EN
  localparam logic [16:0] TO_LOAD = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] idle_cnt_q;
  logic        in_frame;

  assign in_frame = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);

  // Down-counter reloads on every accepted byte; terminal count 0 means the line stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= TO_LOAD;
    end else if (accept || !in_frame) begin
      idle_cnt_q <= TO_LOAD;
    end else if (idle_cnt_q != 17'd0) begin
      idle_cnt_q <= idle_cnt_q - 17'd1;
    end
  end

  assign timeout_hit = in_frame && !accept && (idle_cnt_q == 17'd0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      rx_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_HDR) ||
                    (state_nxt == ST_PAYLOAD);
    end
  end

  always_comb begin
    state_nxt = state_q;
    load_cmd  = 1'b0;
    err_set   = 1'b0;
    err_nxt   = ERR_NONE;
    sel_nxt   = SEL_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (accept) begin
          if (idx_q == HDR_LAST) state_nxt = (len_q != 8'd0) ? ST_PAYLOAD : ST_CHECK;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (idx_q == len_q - 8'd1) state_nxt = ST_CHECK;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (id_q == ENCRYPT_ENABLE_CMD_ID) begin
          if (len_q == ENCRYPT_ENABLE_LEN) begin
            load_cmd = 1'b1;
            sel_nxt  = SEL_ENCRYPT_ENABLE;
          end else begin
            err_set = 1'b1;
            err_nxt = ERR_LEN_MISMATCH;
          end
        end else if (id_q == READ_YAW_CMD_ID) begin
          if (len_q == READ_YAW_LEN) begin
            load_cmd = 1'b1;
            sel_nxt  = SEL_READ_YAW;
          end else begin
            err_set = 1'b1;
            err_nxt = ERR_LEN_MISMATCH;
          end
        end else begin
          err_set = 1'b1;
          err_nxt = ERR_UNKNOWN_ID;
        end
        state_nxt = load_cmd ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        if (bus.cmd_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q          <= 8'd0;
      len_q         <= 8'd0;
      idx_q         <= 8'd0;
      buf_q         <= '0;
      cmd_select_q  <= SEL_NONE;
      cmd_payload_q <= '0;
      cmd_len_q     <= 6'd0;
      error_q       <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      error_q <= err_set;
      if (err_set) error_code_q <= err_nxt;
      if (load_cmd) begin
        cmd_select_q  <= sel_nxt;
        cmd_payload_q <= buf_q;
        cmd_len_q     <= (len_q > MAX_PAY_8) ? MAX_PAY_6 : len_q[5:0];
      end
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            id_q  <= bus.rx_data;
            buf_q <= '0;
            idx_q <= 8'd1;
          end
          ST_HDR: begin
            if (idx_q == 8'd1) len_q <= bus.rx_data;
            // Index restarts at 0 so it doubles as the payload byte index.
            idx_q <= (idx_q == HDR_LAST) ? 8'd0 : idx_q + 8'd1;
          end
          ST_PAYLOAD: begin
            if (idx_q < MAX_PAY_8) buf_q[{idx_q[5:0], 3'b000} +: 8] <= bus.rx_data;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.cmd_valid   = (state_q == ST_OUT);
  assign bus.cmd_select  = cmd_select_q;
  assign bus.cmd_payload = cmd_payload_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.error       = error_q;
  assign bus.error_code  = error_code_q;

endmodule

// File: doc/host_uart_command_dec.md
Name: host_uart_command_dec

Overview:
Receive-side counterpart of the host UART response encoder. Consumes the byte stream from the host UART receiver, assembles framed host commands (7-byte header plus payload) and checks ID and length. Presents one decoded command with the encoder's cmd_select encoding and a 264-bit payload to the command handler over a valid/ready handshake. Protocol errors are flagged; the decoder stays frame-aligned using the declared length.

Parameters:
HDR_BYTES, 7, header bytes per frame: byte0 = command ID, byte1 = payload length L, bytes2..6 reserved (ignored)
MAX_PAYLOAD_BYTES, 33, payload bytes stored (264 bits); bytes beyond this are consumed and dropped
ENCRYPT_ENABLE_CMD_ID, 8'h01, encryption enable/disable command ID; requires L = 1
READ_YAW_CMD_ID, 8'h03, read yaw command ID; requires L = 0
TIMEOUT_CYCLES, 100000, inter-byte timeout (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  rx_data valid
rx_ready  output  1  decoder accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
cmd_valid  output  1  decoded command available
cmd_ready  input  1  handler accepts command
cmd_select  output  16  16'h1 = encrypt enable, 16'h2 = read yaw; 16'h0 otherwise
cmd_payload  output  264  payload byte k at bits [8k+7:8k]; unused bits zero
cmd_len  output  6  number of payload bytes stored
error  output  1  one-cycle pulse on a protocol error
error_code  output  2  1 = unknown ID, 2 = length mismatch, 3 = timeout; holds until the next error or reset

Behaviour:
- Reset (async): state IDLE; rx_ready=0 during reset, then 1 in IDLE; cmd_valid=0, cmd_select=0, cmd_payload=0, cmd_len=0, error=0, error_code=0; byte counter 0. A reset mid-frame discards the partial frame.
- States: IDLE, HDR, PAYLOAD, CHECK, OUT.
- IDLE: rx_ready=1. On an accepted byte: latch ID, clear payload buffer, counter=1, go to HDR.
- HDR: rx_ready=1. Byte1 latches L (8-bit). Bytes 2..6 are ignored.
  - After byte6 is accepted: go to PAYLOAD if L>0, else CHECK.
- PAYLOAD: rx_ready=1. Accepted payload byte index k (0..L-1) is stored if k<MAX_PAYLOAD_BYTES, otherwise dropped.
  - After byte L-1 is accepted, go to CHECK. The 8-bit index cannot wrap because L≤255.
- CHECK (one cycle, rx_ready=0):
  - ID unknown: error pulse, error_code=1, go to IDLE.
  - ID known but L ≠ required length: error pulse, error_code=2, go to IDLE.
  - Otherwise: load cmd_select, cmd_payload, and cmd_len=min(L,33); go to OUT.
- OUT: cmd_valid=1, rx_ready=0. Outputs are stable until cmd_ready is sampled high; then cmd_valid=0 next cycle and go to IDLE. cmd_ready is ignored outside OUT.
- Latency: the last frame byte accepted at edge E gives CHECK in cycle E..E+1; cmd_valid is high from edge E+1. Earliest next-byte acceptance is the edge after the handshake.
- An error never asserts cmd_valid. cmd_select, cmd_payload and cmd_len retain their previous values after an error.

Optional Feature:
HOST_UART_CMD_DEC_TIMEOUT_EN.
- Defined: a 17-bit idle counter runs in HDR/PAYLOAD and resets on each accepted byte. When it reaches TIMEOUT_CYCLES-1: error pulse, error_code=3, go to IDLE, partial frame discarded.
- Undefined: no counter; the decoder waits indefinitely mid-frame; code 3 is never produced.

Decomposition:
- Shared package host_uart_cmd_pkg holds:
  - command/response ID constants (01/02, 03/04)
  - cmd_select encodings
  - HDR_BYTES and MAX_PAYLOAD_BYTES
  - error_code enum
  - state typedef
- The encoder is updated to use the same package.
- No sub-module needed. The optional timeout counter may be a small host_uart_timeout_ctr instance.

Test Plan:
- Encrypt frame 01 01 00 00 00 00 00 01 -> after the last byte, cmd_valid next cycle; cmd_select=16'h1, cmd_payload[7:0]=8'h01 with the rest zero, cmd_len=1, error=0.
- Read yaw 03 00 00 00 00 00 00 -> cmd_select=16'h2, cmd_payload=0, cmd_len=0.
- Unknown frame 07 00 00 00 00 00 00 -> single error pulse, error_code=1, no cmd_valid. A following valid encrypt frame decodes correctly.
- Length mismatch 01 02 00 00 00 00 00 AA BB -> both payload bytes consumed, error_code=2. The next frame decodes aligned.
- Backpressure: hold cmd_ready=0 for 5 cycles in OUT -> rx_ready=0 and outputs stable; on cmd_ready=1, cmd_valid drops next cycle. Also assert reset after 3 header bytes -> all outputs return to reset values and the next frame decodes.
- With HOST_UART_CMD_DEC_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 2 bytes then stall -> error_code=3 exactly 16 cycles after the last byte. A subsequent full frame decodes.
